// File: rtl/frame_parser.sv
// Byte-stream frame parser: hunts for SYNC0/SYNC1, reads a length byte, streams the payload
// and verifies the 8-bit additive checksum, with an idle-cycle watchdog for stalled frames.
module frame_parser #(
  parameter logic [7:0] SYNC0   = 8'h55,
  parameter logic [7:0] SYNC1   = 8'hD5,
  parameter int         MAX_LEN = 64,
  parameter int         TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] iv_data,
  input  logic       i_data_wr,
  output logic [7:0] ov_payload,
  output logic       o_payload_wr,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic [7:0] ov_frame_len
);

  localparam int              TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]      MAX_B    = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  state_t        state, state_n;
  logic [7:0]    len, len_n;
  logic [7:0]    cnt, cnt_n;
  logic [7:0]    sum, sum_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [7:0]    payload_n;
  logic          payload_wr_n;
  logic          done_n;
  logic          err_n;
  logic [7:0]    frame_len_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      len          <= '0;
      cnt          <= '0;
      sum          <= '0;
      tmo          <= '0;
      ov_payload   <= '0;
      o_payload_wr <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      ov_frame_len <= '0;
    end else begin
      state        <= state_n;
      len          <= len_n;
      cnt          <= cnt_n;
      sum          <= sum_n;
      tmo          <= tmo_n;
      ov_payload   <= payload_n;
      o_payload_wr <= payload_wr_n;
      o_frame_done <= done_n;
      o_frame_err  <= err_n;
      ov_frame_len <= frame_len_n;
    end
  end

  always_comb begin
    state_n      = state;
    len_n        = len;
    cnt_n        = cnt;
    sum_n        = sum;
    tmo_n        = tmo;
    payload_n    = ov_payload;
    payload_wr_n = 1'b0;
    done_n       = 1'b0;
    err_n        = 1'b0;
    frame_len_n  = ov_frame_len;

    if (i_data_wr) begin
      tmo_n = '0;
      case (state)
        S_IDLE: begin
          if (iv_data == SYNC0) state_n = S_SYNC;
        end
        S_SYNC: begin
          if (iv_data == SYNC1)      state_n = S_LEN;
          else if (iv_data == SYNC0) state_n = S_SYNC;
          else                       state_n = S_IDLE;
        end
        S_LEN: begin
          if (iv_data != 8'd0 && iv_data <= MAX_B) begin
            len_n   = iv_data;
            cnt_n   = 8'd0;
            sum_n   = iv_data;  // checksum covers the LEN byte too
            state_n = S_PAYLOAD;
          end else begin
            err_n       = 1'b1;
            frame_len_n = iv_data;
            state_n     = S_IDLE;
          end
        end
        S_PAYLOAD: begin
          sum_n        = sum + iv_data;
          cnt_n        = cnt + 8'd1;
          payload_n    = iv_data;
          payload_wr_n = 1'b1;
          if (cnt + 8'd1 == len) state_n = S_CHECK;
        end
        S_CHECK: begin
          if (iv_data == sum) done_n = 1'b1;
          else                err_n  = 1'b1;
          frame_len_n = len;
          state_n     = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      // Watchdog: a stall in SYNC just drops back silently; deeper in the frame it is an error
      if (tmo == TMO_LAST) begin
        tmo_n   = '0;
        state_n = S_IDLE;
        if (state != S_SYNC) begin
          err_n       = 1'b1;
          frame_len_n = (state == S_LEN) ? 8'd0 : len;
        end
      end else begin
        tmo_n = tmo + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_parser.sv
// Directed bench for frame_parser: a negedge monitor logs strobes and pulses with cycle stamps,
// the stimulus thread sends hand-built frames and compares the log against hand-computed values.
module tb_frame_parser;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] iv_data;
  logic       i_data_wr;
  logic [7:0] ov_payload;
  logic       o_payload_wr;
  logic       o_frame_done;
  logic       o_frame_err;
  logic [7:0] ov_frame_len;

  frame_parser #(
    .SYNC0  (8'h55),
    .SYNC1  (8'hD5),
    .MAX_LEN(64),
    .TIMEOUT(16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .iv_data     (iv_data),
    .i_data_wr   (i_data_wr),
    .ov_payload  (ov_payload),
    .o_payload_wr(o_payload_wr),
    .o_frame_done(o_frame_done),
    .o_frame_err (o_frame_err),
    .ov_frame_len(ov_frame_len)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         both_cnt = 0;
  int         pl_cnt   = 0;
  int         done_cyc = -1;
  int         err_cyc  = -1;
  logic [7:0] pl_mem [0:511];
  int         pl_cyc [0:511];

  always @(negedge i_clk) begin
    if (o_payload_wr) begin
      pl_mem[pl_cnt] <= ov_payload;
      pl_cyc[pl_cnt] <= cyc;
      pl_cnt         <= pl_cnt + 1;
    end
    if (o_frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (o_frame_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (o_frame_done && o_frame_err) both_cnt <= both_cnt + 1;
  end

  int checks = 0;
  int errs   = 0;
  int pl_rd  = 0;
  int sent_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge i_clk);
    iv_data   = b;
    i_data_wr = 1'b1;
    sent_cyc  = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_data_wr = 1'b0;
    end
    #1;
  endtask

  task automatic chk_pl(input string tag, input logic [7:0] b);
    chk(tag, 32'(pl_mem[pl_rd]), 32'(b));
    pl_rd++;
  endtask

  task automatic frame3(input logic [7:0] ck);
    send(8'h55); send(8'hD5); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33);
    send(ck);
    idle(3);
  endtask

  task automatic send_gap(input logic [7:0] b);
    send(b);
    idle(3);
  endtask

  initial begin
    i_rst     = 1'b1;
    iv_data   = 8'h00;
    i_data_wr = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_payload", 32'(ov_payload), 32'h0);
    chk("rst_wr", 32'(o_payload_wr), 32'h0);
    chk("rst_done", 32'(o_frame_done), 32'h0);
    chk("rst_err", 32'(o_frame_err), 32'h0);
    chk("rst_len", 32'(ov_frame_len), 32'h0);
    i_rst = 1'b0;
    idle(2);

    // Good frame, contiguous
    frame3(8'h69);
    chk("good_plcnt", pl_cnt, pl_rd + 3);
    chk("good_pl_lat", pl_cyc[pl_rd], 32'(pl_cyc[pl_rd]));
    chk("good_pl_consec", pl_cyc[pl_rd + 2] - pl_cyc[pl_rd], 2);
    chk_pl("good_pl0", 8'h11);
    chk_pl("good_pl1", 8'h22);
    chk_pl("good_pl2", 8'h33);
    chk("good_done", done_cnt, 1);
    chk("good_done_lat", done_cyc - sent_cyc, 1);
    chk("good_err", err_cnt, 0);
    chk("good_len", 32'(ov_frame_len), 32'h03);

    // Bad checksum
    frame3(8'h6A);
    chk("bad_plcnt", pl_cnt, pl_rd + 3);
    chk_pl("bad_pl0", 8'h11);
    chk_pl("bad_pl1", 8'h22);
    chk_pl("bad_pl2", 8'h33);
    chk("bad_err", err_cnt, 1);
    chk("bad_err_lat", err_cyc - sent_cyc, 1);
    chk("bad_done", done_cnt, 1);
    chk("bad_len", 32'(ov_frame_len), 32'h03);

    // Length violations
    send(8'h55); send(8'hD5); send(8'h00); idle(2);
    chk("len0_err", err_cnt, 2);
    chk("len0_lat", err_cyc - sent_cyc, 1);
    chk("len0_len", 32'(ov_frame_len), 32'h00);
    send(8'h55); send(8'hD5); send(8'h41); idle(2);
    chk("len41_err", err_cnt, 3);
    chk("len41_len", 32'(ov_frame_len), 32'h41);
    chk("len_nopl", pl_cnt, pl_rd);
    chk("len_done", done_cnt, 1);

    // Largest legal length: 64 bytes of 01, CHK = 40 + 40 = 80
    send(8'h55); send(8'hD5); send(8'h40);
    for (int i = 0; i < 64; i++) send(8'h01);
    send(8'h80);
    idle(3);
    chk("max_plcnt", pl_cnt, pl_rd + 64);
    pl_rd = pl_rd + 63;
    chk_pl("max_pl_last", 8'h01);
    chk("max_done", done_cnt, 2);
    chk("max_len", 32'(ov_frame_len), 32'h40);

    // Resync with gaps, wrong then right checksum (02+FF+02 = 03)
    send_gap(8'h55); send_gap(8'h55); send_gap(8'hD5); send_gap(8'h02);
    send_gap(8'hFF); send_gap(8'h02); send_gap(8'h01);
    chk("gap_plcnt", pl_cnt, pl_rd + 2);
    chk_pl("gap_pl0", 8'hFF);
    chk_pl("gap_pl1", 8'h02);
    chk("gap_err", err_cnt, 4);
    chk("gap_len", 32'(ov_frame_len), 32'h02);
    send_gap(8'h55); send_gap(8'h55); send_gap(8'hD5); send_gap(8'h02);
    send_gap(8'hFF); send_gap(8'h02); send_gap(8'h03);
    chk_pl("gap2_pl0", 8'hFF);
    chk_pl("gap2_pl1", 8'h02);
    chk("gap2_done", done_cnt, 3);
    chk("gap2_err", err_cnt, 4);

    // Payload timeout after 16 idle cycles
    send(8'h55); send(8'hD5); send(8'h04); send(8'hAA);
    idle(16);
    chk("tmo_early", err_cnt, 4);
    idle(1);
    chk("tmo_err", err_cnt, 5);
    chk("tmo_lat", err_cyc - sent_cyc, 17);
    chk("tmo_len", 32'(ov_frame_len), 32'h04);
    chk("tmo_plcnt", pl_cnt, pl_rd + 1);
    chk_pl("tmo_pl", 8'hAA);
    frame3(8'h69);
    pl_rd = pl_rd + 3;
    chk("tmo_next_done", done_cnt, 4);

    // SYNC stall drops back silently; the late frame body is then ignored
    send(8'h55); idle(20);
    send(8'hD5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    idle(20);
    chk("sync_tmo_pl", pl_cnt, pl_rd);
    chk("sync_tmo_done", done_cnt, 4);
    chk("sync_tmo_err", err_cnt, 5);

    // Asynchronous reset mid-payload
    send(8'h55); send(8'hD5); send(8'h04); send(8'h10); send(8'h20);
    @(negedge i_clk);
    i_data_wr = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    chk("mrst_payload", 32'(ov_payload), 32'h0);
    chk("mrst_wr", 32'(o_payload_wr), 32'h0);
    chk("mrst_len", 32'(ov_frame_len), 32'h0);
    chk("mrst_flags", 32'({o_frame_done, o_frame_err}), 32'h0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    idle(2);
    chk_pl("mrst_pl0", 8'h10);
    chk_pl("mrst_pl1", 8'h20);
    chk("mrst_err", err_cnt, 5);
    chk("mrst_done", done_cnt, 4);
    frame3(8'h69);
    pl_rd = pl_rd + 3;
    chk("mrst_next_done", done_cnt, 5);
    chk("mrst_next_len", 32'(ov_frame_len), 32'h03);

    chk("final_plcnt", pl_cnt, pl_rd);
    chk("never_both", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
